// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change path: state encoding, coin values and
// helpers for choosing a coin and working out the change value.
package vending_pkg;

  localparam int REM_W   = 6;
  localparam int COIN_10 = 10;
  localparam int COIN_5  = 5;
  localparam int COIN_1  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_10   = 2'd1,
    SEL_5    = 2'd2,
    SEL_1    = 2'd3
  } coin_sel_t;

  // Highest denomination that still has coins left to eject.
  function automatic coin_sel_t pick_coin(input logic [1:0] n10, input logic n5,
                                          input logic [2:0] n1);
    coin_sel_t sel;
    if (n10 != 2'd0)     sel = SEL_10;
    else if (n5)         sel = SEL_5;
    else if (n1 != 3'd0) sel = SEL_1;
    else                 sel = SEL_NONE;
    return sel;
  endfunction

  function automatic logic [REM_W-1:0] coin_value(input coin_sel_t sel);
    logic [REM_W-1:0] val;
    case (sel)
      SEL_10:  val = REM_W'(COIN_10);
      SEL_5:   val = REM_W'(COIN_5);
      SEL_1:   val = REM_W'(COIN_1);
      default: val = '0;
    endcase
    return val;
  endfunction

  // Maximum is 3*10 + 5 + 7 = 42, so the sum never overflows REM_W bits.
  function automatic logic [REM_W-1:0] change_value(input logic [1:0] n10, input logic n5,
                                                    input logic [2:0] n1);
    return REM_W'(COIN_10) * {4'b0, n10}
         + REM_W'(COIN_5)  * {5'b0, n5}
         + REM_W'(COIN_1)  * {3'b0, n1};
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/eject/status bundle between the vending control logic and the
// coin dispenser.
interface change_dispenser_if
  import vending_pkg::*;
  ();

  logic             i_start;
  logic [1:0]       i_num_10;
  logic             i_num_5;
  logic [2:0]       i_num_1;
  logic             o_eject_10;
  logic             o_eject_5;
  logic             o_eject_1;
  logic [REM_W-1:0] o_remaining;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_num_10, i_num_5, i_num_1,
    input  o_eject_10, o_eject_5, o_eject_1, o_remaining, o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_10, i_num_5, i_num_1,
    output o_eject_10, o_eject_5, o_eject_1, o_remaining, o_busy, o_done
  );

endinterface

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter timing both the eject pulse and the gap after it.
// Loading L-1 gives an expire flag on the L-th cycle after the load edge.
module dispense_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk) begin
    if (reset)             r_cnt <= '0;
    else if (i_load)       r_cnt <= i_load_val;
    else if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin dispenser: latches the change counts and ejects coins one at a time,
// highest denomination first, with a fixed pulse and gap per coin.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for i_start; counts latched on the accepting edge
// ST_PULSE | eject line of the current denomination held high
// ST_GAP   | all eject lines low between coins
// ST_DONE  | one-cycle completion pulse, then back to idle
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_LEN = 200,
  parameter int GAP_LEN   = 300,
  parameter int CNT_W     = 9
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_n10, w_n10_nxt;
  logic             r_n5, w_n5_nxt;
  logic [2:0]       r_n1, w_n1_nxt;
  logic [REM_W-1:0] r_remaining, w_rem_nxt;
  logic             r_eject_10, r_eject_5, r_eject_1, r_busy, r_done;
  coin_sel_t        w_sel, w_sel_nxt;
  logic             w_load, w_expire;
  logic [CNT_W-1:0] w_load_val;

  dispense_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  assign w_sel = pick_coin(r_n10, r_n5, r_n1);

  // Next state, next coin counts and next remaining value.
  always_comb begin
    w_state_nxt = r_state;
    w_n10_nxt   = r_n10;
    w_n5_nxt    = r_n5;
    w_n1_nxt    = r_n1;
    w_rem_nxt   = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_n10_nxt   = bus.i_num_10;
          w_n5_nxt    = bus.i_num_5;
          w_n1_nxt    = bus.i_num_1;
          w_rem_nxt   = change_value(bus.i_num_10, bus.i_num_5, bus.i_num_1);
          w_state_nxt = (w_rem_nxt != '0) ? ST_PULSE : ST_DONE;
        end
      end
      ST_PULSE: begin
        if (w_expire) begin
          case (w_sel)
            SEL_10:  w_n10_nxt = r_n10 - 2'd1;
            SEL_5:   w_n5_nxt  = 1'b0;
            SEL_1:   w_n1_nxt  = r_n1 - 3'd1;
            default: ;
          endcase
          w_rem_nxt   = r_remaining - coin_value(w_sel);
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_expire)
          w_state_nxt = (w_sel != SEL_NONE) ? ST_PULSE : ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every edge that enters PULSE or GAP.
  always_comb begin
    w_load     = ((w_state_nxt == ST_PULSE) && (r_state != ST_PULSE)) ||
                 ((w_state_nxt == ST_GAP)   && (r_state != ST_GAP));
    w_load_val = (w_state_nxt == ST_PULSE) ? CNT_W'(PULSE_LEN - 1) : CNT_W'(GAP_LEN - 1);
    w_sel_nxt  = pick_coin(w_n10_nxt, w_n5_nxt, w_n1_nxt);
  end

  // State, latched counts and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_n10       <= '0;
      r_n5        <= 1'b0;
      r_n1        <= '0;
      r_remaining <= '0;
      r_eject_10  <= 1'b0;
      r_eject_5   <= 1'b0;
      r_eject_1   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n10       <= w_n10_nxt;
      r_n5        <= w_n5_nxt;
      r_n1        <= w_n1_nxt;
      r_remaining <= w_rem_nxt;
      r_eject_10  <= (w_state_nxt == ST_PULSE) && (w_sel_nxt == SEL_10);
      r_eject_5   <= (w_state_nxt == ST_PULSE) && (w_sel_nxt == SEL_5);
      r_eject_1   <= (w_state_nxt == ST_PULSE) && (w_sel_nxt == SEL_1);
      r_busy      <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_GAP);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.o_eject_10  = r_eject_10;
  assign bus.o_eject_5   = r_eject_5;
  assign bus.o_eject_1   = r_eject_1;
  assign bus.o_remaining = r_remaining;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_LEN=2, GAP_LEN=1: every coin
// takes 3 cycles (pulse on cycles 3j+1, 3j+2, gap on 3j+3 after the start edge)
// and o_done lands on cycle 3N+1.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   q_exp[$];

  change_dispenser_if bus();

  change_dispenser #(.PULSE_LEN(2), .GAP_LEN(1), .CNT_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] eject_pat(input int den);
    case (den)
      10:      return 3'b100;
      5:       return 3'b010;
      1:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Start a dispense with the given counts and check every cycle up to o_done
  // against q_exp. disturb: 0 none, 1 change counts after acceptance,
  // 2 extra start request while busy.
  task automatic run_and_check(input int n10, input int n5, input int n1,
                               input int exp_total, input int disturb);
    int n;
    int rem;
    int j;
    int ph;
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_num_10 = 2'(n10);
    bus.i_num_5  = 1'(n5);
    bus.i_num_1  = 3'(n1);
    @(posedge clk);
    n   = q_exp.size();
    rem = exp_total;
    for (int c = 1; c <= 3 * n + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.i_start = 1'b0;
        if (disturb == 1) begin
          bus.i_num_10 = 2'd0;
          bus.i_num_5  = 1'b1;
          bus.i_num_1  = 3'd0;
        end
      end
      if (c <= 3 * n) begin
        j  = (c - 1) / 3;
        ph = (c - 1) % 3;
        if (ph == 2) rem = rem - q_exp[j];
        chk($sformatf("eject c%0d", c), {29'd0, bus.o_eject_10, bus.o_eject_5, bus.o_eject_1},
            {29'd0, (ph < 2) ? eject_pat(q_exp[j]) : 3'b000});
        chk($sformatf("busy c%0d", c), {31'd0, bus.o_busy}, 32'd1);
        chk($sformatf("done c%0d", c), {31'd0, bus.o_done}, 32'd0);
      end else begin
        chk($sformatf("eject c%0d", c), {29'd0, bus.o_eject_10, bus.o_eject_5, bus.o_eject_1}, 32'd0);
        chk($sformatf("busy c%0d", c), {31'd0, bus.o_busy}, 32'd0);
        chk($sformatf("done c%0d", c), {31'd0, bus.o_done}, 32'd1);
      end
      chk($sformatf("remaining c%0d", c), {26'd0, bus.o_remaining}, 32'(rem));
      if (disturb == 2 && c == 5) begin
        bus.i_start  = 1'b1;
        bus.i_num_10 = 2'd0;
        bus.i_num_5  = 1'b0;
        bus.i_num_1  = 3'd5;
      end
      if (disturb == 2 && c == 6) bus.i_start = 1'b0;
    end
    @(negedge clk);
    chk("idle done", {31'd0, bus.o_done}, 32'd0);
    chk("idle busy", {31'd0, bus.o_busy}, 32'd0);
    chk("idle remaining", {26'd0, bus.o_remaining}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_num_10 = 2'd0;
    bus.i_num_5  = 1'b0;
    bus.i_num_1  = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset eject", {29'd0, bus.o_eject_10, bus.o_eject_5, bus.o_eject_1}, 32'd0);
    chk("reset busy", {31'd0, bus.o_busy}, 32'd0);
    chk("reset done", {31'd0, bus.o_done}, 32'd0);
    chk("reset remaining", {26'd0, bus.o_remaining}, 32'd0);
    reset = 1'b0;

    // Zero change: done on cycle 1, nothing ejected.
    q_exp = {};
    run_and_check(0, 0, 0, 0, 0);

    // Mixed change 1/1/2 = 17, with a start request injected mid-run.
    q_exp = {10, 5, 1, 1};
    run_and_check(1, 1, 2, 17, 2);

    // Maximum change 3/1/7 = 42.
    q_exp = {10, 10, 10, 5, 1, 1, 1, 1, 1, 1, 1};
    run_and_check(3, 1, 7, 42, 0);

    // Counts changed after acceptance: 2/0/3 = 23 must still be paid out.
    q_exp = {10, 10, 1, 1, 1};
    run_and_check(2, 0, 3, 23, 1);

    // Reset in the second pulse (cycle 4) of a 1/1/2 run.
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_num_10 = 2'd1;
    bus.i_num_5  = 1'b1;
    bus.i_num_1  = 3'd2;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_start = 1'b0;
    end
    chk("pre-reset eject5", {29'd0, bus.o_eject_10, bus.o_eject_5, bus.o_eject_1}, 32'd2);
    chk("pre-reset remaining", {26'd0, bus.o_remaining}, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset eject", {29'd0, bus.o_eject_10, bus.o_eject_5, bus.o_eject_1}, 32'd0);
    chk("post-reset busy", {31'd0, bus.o_busy}, 32'd0);
    chk("post-reset done", {31'd0, bus.o_done}, 32'd0);
    chk("post-reset remaining", {26'd0, bus.o_remaining}, 32'd0);
    reset = 1'b0;

    // Single 1-unit coin after reset: done on cycle 4.
    q_exp = {1};
    run_and_check(0, 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
